// File: rtl/uart_tx_core_if.sv
// Transmit request / serial line bundle between a requester and uart_tx_core.
interface uart_tx_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// each bit held for a latched number of clk cycles.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  uart_tx_core_if.slave  bus
);

  localparam int unsigned PRE_W = 6;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [PRE_W-1:0]      edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [PRE_W-1:0]      pre_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_done;

  // Last clk cycle of the current bit period.
  assign bit_done = (edge_cnt == (pre_q - PRE_W'(1)));

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

  // Frame sequencer; tx_out and busy come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      sh_q      <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (bus.data_valid && (bus.prescale != PRE_W'(0))) begin
            sh_q      <= bus.p_data;
            pre_q     <= bus.prescale;
            par_en_q  <= bus.par_en;
            par_bit_q <= (^bus.p_data) ^ bus.par_typ;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= sh_q[0];
            sh_q     <= sh_q >> 1;
            state    <= S_DATA;
          end else begin
            edge_cnt <= edge_cnt + PRE_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                tx_q  <= par_bit_q;
                state <= S_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx_q    <= sh_q[0];
              sh_q    <= sh_q >> 1;
            end
          end else begin
            edge_cnt <= edge_cnt + PRE_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            edge_cnt <= '0;
            tx_q     <= 1'b1;
            state    <= S_STOP;
          end else begin
            edge_cnt <= edge_cnt + PRE_W'(1);
          end
        end

        S_STOP: begin
          if (bit_done) begin
            edge_cnt <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            edge_cnt <= edge_cnt + PRE_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shapes, parity, back-to-back,
// mid-frame disturbance, reset abort and zero prescale.
module tb_uart_tx_core;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_core_if #(.DATA_WIDTH(8)) u_if ();

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    u_if.p_data     = d;
    u_if.par_en     = pe;
    u_if.par_typ    = pt;
    u_if.prescale   = ps;
    u_if.data_valid = 1'b1;
  endtask

  // Called at the negedge where the request was driven; checks every cycle
  // of the expected frame and then the first idle cycle.
  task automatic check_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps, input logic hold,
                             input logic [7:0] nd, input logic disturb);
    logic exp_bits [11];
    int   nb;
    int   total;
    int   k;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
    exp_bits[9]  = pe ? ((^d) ^ pt) : 1'b1;
    exp_bits[10] = 1'b1;
    nb    = pe ? 11 : 10;
    total = nb * int'(ps);
    k     = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < int'(ps); c++) begin
        @(negedge clk);
        chk($sformatf("%s tx b%0d c%0d", name, b, c), {7'd0, u_if.tx_out}, {7'd0, exp_bits[b]});
        chk($sformatf("%s busy b%0d c%0d", name, b, c), {7'd0, u_if.busy}, 8'd1);
        if (k == 0) begin
          u_if.p_data = nd;
          if (!hold) u_if.data_valid = 1'b0;
        end
        if (disturb) begin
          u_if.p_data     = ~d;
          u_if.par_en     = ~pe;
          u_if.par_typ    = ~pt;
          u_if.prescale   = ps + 6'd3;
          u_if.data_valid = ((k % 7) == 3) && (k != total - 1);
        end
        k++;
      end
    end
    @(negedge clk);
    chk({name, " idle tx"}, {7'd0, u_if.tx_out}, 8'd1);
    chk({name, " idle busy"}, {7'd0, u_if.busy}, 8'd0);
    if (!hold) u_if.data_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b0;
    u_if.p_data     = 8'h00;
    u_if.data_valid = 1'b1;
    u_if.par_en     = 1'b0;
    u_if.par_typ    = 1'b0;
    u_if.prescale   = 6'd8;

    // Reset holds idle even with a pending request.
    repeat (3) @(negedge clk);
    chk("reset tx", {7'd0, u_if.tx_out}, 8'd1);
    chk("reset busy", {7'd0, u_if.busy}, 8'd0);
    u_if.data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset tx", {7'd0, u_if.tx_out}, 8'd1);
    chk("post-reset busy", {7'd0, u_if.busy}, 8'd0);

    // 0xA5, no parity, prescale 8.
    drive(8'hA5, 1'b0, 1'b0, 6'd8);
    check_frame("a5_np", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 8'hA5, 1'b0);

    // 0xA5 even parity, then odd parity.
    drive(8'hA5, 1'b1, 1'b0, 6'd8);
    check_frame("a5_even", 8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 8'hA5, 1'b0);
    drive(8'hA5, 1'b1, 1'b1, 6'd8);
    check_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 6'd8, 1'b0, 8'hA5, 1'b0);

    // Back-to-back with data_valid held high.
    drive(8'h3C, 1'b0, 1'b0, 6'd4);
    check_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 6'd4, 1'b1, 8'hC3, 1'b0);
    check_frame("b2b_c3", 8'hC3, 1'b0, 1'b0, 6'd4, 1'b0, 8'hC3, 1'b0);

    // Inputs churn mid-frame and extra requests while busy.
    drive(8'h96, 1'b1, 1'b1, 6'd5);
    check_frame("disturb", 8'h96, 1'b1, 1'b1, 6'd5, 1'b0, 8'h96, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no extra frame busy", {7'd0, u_if.busy}, 8'd0);
      chk("no extra frame tx", {7'd0, u_if.tx_out}, 8'd1);
    end

    // Reset during data bit 3, with a simultaneous request.
    drive(8'hA5, 1'b0, 1'b0, 6'd4);
    @(negedge clk);
    u_if.data_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre-abort tx bit3", {7'd0, u_if.tx_out}, 8'd0);
    chk("pre-abort busy", {7'd0, u_if.busy}, 8'd1);
    rst = 1'b0;
    u_if.data_valid = 1'b1;
    @(negedge clk);
    chk("abort tx", {7'd0, u_if.tx_out}, 8'd1);
    chk("abort busy", {7'd0, u_if.busy}, 8'd0);
    rst = 1'b1;
    u_if.data_valid = 1'b0;
    @(negedge clk);
    chk("after abort tx", {7'd0, u_if.tx_out}, 8'd1);
    chk("after abort busy", {7'd0, u_if.busy}, 8'd0);
    drive(8'h5A, 1'b1, 1'b1, 6'd3);
    check_frame("post_reset_5a", 8'h5A, 1'b1, 1'b1, 6'd3, 1'b0, 8'h5A, 1'b0);

    // Zero prescale is ignored; prescale 1 gives one cycle per bit.
    drive(8'hFF, 1'b0, 1'b0, 6'd0);
    repeat (4) begin
      @(negedge clk);
      chk("ps0 tx", {7'd0, u_if.tx_out}, 8'd1);
      chk("ps0 busy", {7'd0, u_if.busy}, 8'd0);
    end
    u_if.prescale = 6'd1;
    check_frame("ps1", 8'hFF, 1'b0, 1'b0, 6'd1, 1'b0, 8'hFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 clk  input  1  single block clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 data_valid  input  1  transmit request; qualifies p_data and config.
REQ-006 par_en  input  1  1 = parity bit inserted after data.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 prescale  input  6  clk cycles per serial bit.
REQ-009 tx_out  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  frame in progress, registered.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 Acceptance SHALL occur only in IDLE, in any cycle with data_valid=1 and prescale!=0; data_valid ignored in all other states.
REQ-013 On acceptance, p_data, par_en, par_typ and prescale SHALL be latched; later input changes SHALL NOT affect the frame in flight.
REQ-014 data_valid=1 with prescale=0 SHALL be ignored: stay IDLE, tx_out=1, busy=0.
REQ-015 Latency: tx_out SHALL drive the start bit (0) and busy SHALL rise in the cycle after the acceptance edge.
REQ-016 Every bit (start, data, parity, stop) SHALL last exactly latched-prescale cycles, timed by a 6-bit edge counter running 0..prescale-1 and cleared on each bit boundary.
REQ-017 DATA SHALL send the latched byte LSB first, with a bit counter 0..DATA_WIDTH-1; after bit DATA_WIDTH-1, go to PARITY if par_en=1, else STOP.
REQ-018 Parity bit SHALL equal XOR of latched data when par_typ=0, and its inverse when par_typ=1.
REQ-019 STOP SHALL drive tx_out=1 for one bit period, then return to IDLE; busy SHALL be 0 from the first IDLE cycle.
REQ-020 Frame length SHALL be (10+par_en)*prescale cycles of busy=1; back-to-back frames SHALL have a minimum one-cycle IDLE gap with tx_out=1.
REQ-021 tx_out SHALL be driven from a flop only, glitch-free, and 1 in IDLE.
REQ-022 Illegal state encodings SHALL recover to IDLE on the next edge, with tx_out=1 and busy=0.

Reset
REQ-023 At a rising clk edge with rst=0: state=IDLE, tx_out=1, busy=0, counters=0, latched registers=0.
REQ-024 Reset mid-frame SHALL abort the frame; tx_out=1 and busy=0 from that edge, with no partial bit completion.
REQ-025 rst=0 SHALL take priority over a simultaneous data_valid=1; no acceptance in that cycle.

Verification
REQ-026 p_data=0xA5, par_en=0, prescale=8, data_valid pulse -> tx_out 0,1,0,1,0,0,1,0,1,1, each for 8 cycles; busy high 80 cycles, then 0.
REQ-027 p_data=0xA5, par_en=1, par_typ=0 -> parity bit 0, 88 busy cycles; same frame with par_typ=1 -> parity bit 1.
REQ-028 data_valid held high, p_data 0x3C then 0xC3, prescale=4 -> two complete frames separated by exactly one idle cycle; second frame carries 0xC3.
REQ-029 p_data, par_en and prescale changed mid-frame, plus a data_valid pulse while busy=1 -> frame unchanged, no extra frame.
REQ-030 rst=0 in data bit 3 -> tx_out=1 and busy=0 at that edge; next request after release sends a full correct frame.
REQ-031 data_valid=1 with prescale=0 -> tx_out stays 1 and busy stays 0; then prescale=1 -> 10-cycle frame, one cycle per bit.
